alu_cmd_queue: RTL
==================

# alu_cmd_queue

Command queue and issue stage directly upstream of the 8-bit ALU. It accepts ALU commands (opcode plus two operands) over a valid/ready handshake and buffers them in a small FIFO. It issues them to the ALU as registered single-cycle `valid_in` pulses, and watches the ALU's `valid_out`/`result` to track in-flight operations. Optionally, it forwards the previous ALU result as operand A for chained commands.

## Interface
- `DEPTH`, default 4: FIFO entries; power of 2, ≥2.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  upstream command valid.
- `s_ready`  out  1  queue can accept; equals `!full`, with no combinational path from `s_valid`.
- `s_opcode`  in  2  operation: 00 ADD, 01 SUB, 10 AND, 11 OR.
- `s_a`, `s_b`  in  8 each  operands.
- `s_use_prev`  in  1  replace operand A with the previous ALU result. Honoured only with `ALU_CMDQ_FWD_EN`.
- `flush`  in  1  synchronous clear of all queued, not-yet-issued commands.
- `alu_opcode`  out  2  registered opcode to the ALU.
- `alu_operand_a`, `alu_operand_b`  out  8 each  registered operands to the ALU.
- `alu_valid_in`  out  1  registered issue pulse; high for exactly one cycle per command.
- `alu_result`  in  8  ALU result.
- `alu_valid_out`  in  1  ALU result valid.
- `count`  out  $clog2(DEPTH)+1  number of queued entries.
- `outstanding`  out  2  commands issued whose `alu_valid_out` has not yet been seen.

## Operation
- **Push:** occurs when `s_valid && s_ready` at an edge. The entry is written at the write pointer {opcode, a, b, use_prev}.
- **Pointers:** wrap modulo DEPTH. Full/empty are distinguished by an extra pointer MSB.
- **Pop/issue:** occurs at an edge when the FIFO is non-empty and the head is issuable.
  - On issue, `alu_*` registers are loaded from the head and `alu_valid_in` is set to 1.
  - If there is no issue, `alu_valid_in` goes to 0. Operand registers hold their last values.
- **Issuable:** an independent head (`use_prev=0`) is always issuable. This allows one issue per cycle.
- **Dependent head** (`use_prev=1`, FWD build only):
  - It is issuable iff `outstanding==0`, or `outstanding==1 && alu_valid_out`.
  - `alu_operand_a` is loaded from `alu_valid_out ? alu_result : last_result`.
  - `last_result` captures `alu_result` on every `alu_valid_out`. It resets to 0.
- **Outstanding counter:** +1 on issue, −1 on `alu_valid_out`, both in the same cycle nets to 0.
  - Max value is 2, since the ALU has a fixed 1-cycle latency.
  - `alu_valid_out` while `outstanding==0` is ignored and the counter saturates at 0.
- **Push and pop in the same edge:** both occur and `count` is unchanged. No push when full: `s_ready` is 0, with no same-cycle bypass.
- **Empty FIFO:** there is no input-to-output bypass; a command always passes through the FIFO.
- **Flush:**
  - Pointers and `count` go to 0 and any same-cycle push is dropped.
  - The same-cycle issue is suppressed, so `alu_valid_in` goes to 0.
  - `outstanding` and `last_result` keep tracking normally.
- **Reset values:**
  - `alu_valid_in`=0, `alu_opcode`=0, operands=0.
  - `count`=0, `outstanding`=0, `s_ready`=1, `last_result`=0.
- **Reset mid-operation:** all queued and in-flight tracking is discarded immediately. Any ALU result arriving after reset is ignored.

## Timing
- Command accepted at edge E0 → earliest `alu_valid_in` high during the cycle after E1. The latency is 2 edges.
- Independent commands sustain 1 issue per cycle.
- A dependent command following its producer:
  - Producer issued at E1 → ALU samples at E2 → `alu_valid_out` high after E2 → dependent issues at E3.
  - This is exactly one bubble cycle.
- `s_ready` reflects state after the previous edge. It deasserts in the cycle after the push that fills the FIFO.

## Configuration
- Macro: `ALU_CMDQ_FWD_EN`.
- **Defined:** `s_use_prev` is stored and honoured. The `last_result` register and the dependent-issue stall logic are present.
- **Undefined:**
  - `s_use_prev` is ignored and not stored; every command is independent and `last_result` is absent.
  - `outstanding` is still maintained.

## Test plan
- **Reset state:** assert `rst_n`=0 mid-stream with 3 queued → next cycle `count`=0, `outstanding`=0, `alu_valid_in`=0, `s_ready`=1.
- **Back-to-back issue:** push ADD 0x10,0x20 then OR 0xF0,0x0F on consecutive cycles → `alu_valid_in` high on 2 consecutive cycles with those exact operands, in order.
- **Full FIFO:** hold `s_valid`, then stall by flushing nothing and pushing 5 with DEPTH=4 and no pops possible (forced via dependent head blocked) → `s_ready`=0 after 4th push; 5th is not accepted until a pop.
- **Forwarding (FWD):** push ADD 0x05,0x03 then SUB use_prev b=0x02 → second issue one bubble later with `alu_operand_a`=0x08, `alu_operand_b`=0x02.
- **Flush:** 3 queued and flush asserted in the same cycle as a push → `count`=0 next cycle, no further `alu_valid_in`, `outstanding` still decrements on the pending `alu_valid_out`.
- **Wrap-around:** stream 10 independent commands with random back-pressure → issue order and operands match push order exactly; pointers wrap without loss.

Source files
------------

// File: rtl/alu_cmd_queue.sv
// rtl/alu_cmd_queue.sv - ALU command FIFO and registered issue stage with in-flight tracking
// Define ALU_CMDQ_FWD_EN to store s_use_prev and forward the previous ALU result as operand A.
module alu_cmd_queue #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [1:0]             s_opcode,
    input  logic [7:0]             s_a,
    input  logic [7:0]             s_b,
    input  logic                   s_use_prev,
    input  logic                   flush,
    output logic [1:0]             alu_opcode,
    output logic [7:0]             alu_operand_a,
    output logic [7:0]             alu_operand_b,
    output logic                   alu_valid_in,
    input  logic [7:0]             alu_result,
    input  logic                   alu_valid_out,
    output logic [$clog2(DEPTH):0] count,
    output logic [1:0]             outstanding
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [1:0]    r_mem_op [DEPTH];
    logic [7:0]    r_mem_a  [DEPTH];
    logic [7:0]    r_mem_b  [DEPTH];
    logic [1:0]    r_alu_opcode;
    logic [7:0]    r_alu_a;
    logic [7:0]    r_alu_b;
    logic          r_alu_valid;
    logic [1:0]    r_outstanding;

    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_issue;
    logic          w_issuable;
    logic          w_dec;
    logic [7:0]    w_head_a;

    assign w_wr_idx = r_wr_ptr[AW-1:0];
    assign w_rd_idx = r_rd_ptr[AW-1:0];
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_idx == w_rd_idx);
    // Flush wins over both ends of the FIFO in the same edge.
    assign w_push   = s_valid && !w_full && !flush;
    assign w_issue  = !w_empty && w_issuable && !flush;
    assign w_dec    = alu_valid_out && (r_outstanding != 2'd0);

`ifdef ALU_CMDQ_FWD_EN
    logic       r_mem_dep [DEPTH];
    logic [7:0] r_last_result;
    logic       w_head_dep;
    logic       w_dep_ok;

    assign w_head_dep = r_mem_dep[w_rd_idx];
    // Dependent head waits until its producer's result is visible this cycle or already captured.
    assign w_dep_ok   = (r_outstanding == 2'd0) || ((r_outstanding == 2'd1) && alu_valid_out);
    assign w_issuable = !w_head_dep || w_dep_ok;
    assign w_head_a   = w_head_dep ? (alu_valid_out ? alu_result : r_last_result)
                                   : r_mem_a[w_rd_idx];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_dep[w_wr_idx] <= s_use_prev;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_result <= '0;
        end else if (alu_valid_out) begin
            r_last_result <= alu_result;
        end
    end
`else
    logic w_unused_fwd;

    assign w_unused_fwd = ^{s_use_prev, alu_result};
    assign w_issuable   = 1'b1;
    assign w_head_a     = r_mem_a[w_rd_idx];
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_op[w_wr_idx] <= s_opcode;
            r_mem_a[w_wr_idx]  <= s_a;
            r_mem_b[w_wr_idx]  <= s_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Operand registers hold their last values when nothing issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_opcode <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_valid  <= 1'b0;
        end else begin
            r_alu_valid <= w_issue;
            if (w_issue) begin
                r_alu_opcode <= r_mem_op[w_rd_idx];
                r_alu_a      <= w_head_a;
                r_alu_b      <= r_mem_b[w_rd_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
        end else if (w_issue && !w_dec && (r_outstanding != 2'd3)) begin
            r_outstanding <= r_outstanding + 2'd1;
        end else if (!w_issue && w_dec) begin
            r_outstanding <= r_outstanding - 2'd1;
        end
    end

    assign s_ready       = !w_full;
    assign count         = r_wr_ptr - r_rd_ptr;
    assign outstanding   = r_outstanding;
    assign alu_opcode    = r_alu_opcode;
    assign alu_operand_a = r_alu_a;
    assign alu_operand_b = r_alu_b;
    assign alu_valid_in  = r_alu_valid;

endmodule
